// File: rtl/timer_pkg.sv
// Shared timer definitions: mode encodings, default count width and the
// state type used by the timer arbiter.
package timer_pkg;

  localparam logic [1:0] MODE_OFF     = 2'b00;
  localparam logic [1:0] MODE_PRESC   = 2'b01;
  localparam logic [1:0] MODE_TRIG    = 2'b10;
  localparam logic [1:0] MODE_ONESHOT = 2'b11;

  localparam int TW_DEFAULT = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_FIRE,
    ST_WAIT_START,
    ST_WAIT_DONE,
    ST_DONE,
    ST_ABORT
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request at or above ptr,
// wrapping around. Reusable by any shared-resource arbiter.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          valid,
  output logic [IW-1:0] idx,
  output logic [N-1:0]  onehot
);

  logic [IW:0] sum;

  // Scan from the farthest offset down so the nearest candidate wins last.
  always_comb begin
    valid  = 1'b0;
    idx    = '0;
    onehot = '0;
    sum    = '0;
    for (int k = N - 1; k >= 0; k--) begin
      sum = {1'b0, ptr} + (IW+1)'(k);
      if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
      if (req[sum[IW-1:0]]) begin
        valid  = 1'b1;
        idx    = sum[IW-1:0];
        onehot = N'(1) << sum[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/timer_arbiter.sv
// Round-robin arbiter/sequencer sharing one one-shot timer among NUM_REQ requesters.
// Define TIMER_ARB_TIMEOUT_EN to bound the wait for the timer to start (err_o).
module timer_arbiter
  import timer_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TW      = TW_DEFAULT,
  parameter int TMO_CYC = 4
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic [NUM_REQ-1:0]    req_i,
  input  logic [NUM_REQ*TW-1:0] req_delay_i,
  input  logic                  tmr_running_i,
  output logic [NUM_REQ-1:0]    grant_o,
  output logic [NUM_REQ-1:0]    done_o,
  output logic [NUM_REQ-1:0]    err_o,
  output logic                  busy_o,
  output logic [1:0]            tmr_mode_o,
  output logic [TW-1:0]         tmr_target_o,
  output logic                  tmr_trig_o,
  output logic                  tmr_clear_o
);

  localparam int IW = $clog2(NUM_REQ);

  arb_state_e           state_reg;
  logic [IW-1:0]        owner_reg;
  logic [IW-1:0]        ptr_reg;
  logic [IW-1:0]        ptr_next;
  logic [TW-1:0]        delay_arr [NUM_REQ];
  logic                 pick_valid;
  logic [IW-1:0]        pick_idx;
  logic [NUM_REQ-1:0]   pick_onehot;
  logic                 owner_req;

  genvar gi;
  for (gi = 0; gi < NUM_REQ; gi++) begin : g_delay
    assign delay_arr[gi] = req_delay_i[gi*TW +: TW];
  end

  rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_pick (
    .req    (req_i),
    .ptr    (ptr_reg),
    .valid  (pick_valid),
    .idx    (pick_idx),
    .onehot (pick_onehot)
  );

  assign ptr_next  = (owner_reg == IW'(NUM_REQ - 1)) ? '0 : owner_reg + 1'b1;
  assign owner_req = req_i[owner_reg];

`ifdef TIMER_ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TMO_CYC + 1);
  logic [TMO_W-1:0] tmo_cnt_reg;
`else
  assign err_o = '0;
`endif

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_reg    <= ST_IDLE;
      owner_reg    <= '0;
      ptr_reg      <= '0;
      grant_o      <= '0;
      done_o       <= '0;
      busy_o       <= 1'b0;
      tmr_mode_o   <= MODE_OFF;
      tmr_target_o <= '0;
      tmr_trig_o   <= 1'b0;
      tmr_clear_o  <= 1'b0;
`ifdef TIMER_ARB_TIMEOUT_EN
      err_o        <= '0;
      tmo_cnt_reg  <= '0;
`endif
    end else begin
      done_o      <= '0;
      tmr_trig_o  <= 1'b0;
      tmr_clear_o <= 1'b0;
`ifdef TIMER_ARB_TIMEOUT_EN
      err_o       <= '0;
`endif
      case (state_reg)
        ST_IDLE: begin
          if (pick_valid) begin
            owner_reg <= pick_idx;
            grant_o   <= pick_onehot;
            busy_o    <= 1'b1;
            // A zero delay never touches the timer.
            if (delay_arr[pick_idx] == '0) begin
              state_reg <= ST_DONE;
            end else begin
              state_reg    <= ST_ARM;
              tmr_mode_o   <= MODE_ONESHOT;
              tmr_target_o <= delay_arr[pick_idx];
              tmr_clear_o  <= 1'b1;
            end
          end
        end
        ST_ARM: begin
          tmr_trig_o <= 1'b1;
          state_reg  <= ST_FIRE;
        end
        ST_FIRE: begin
          state_reg <= ST_WAIT_START;
`ifdef TIMER_ARB_TIMEOUT_EN
          tmo_cnt_reg <= TMO_W'(TMO_CYC);
`endif
        end
        ST_WAIT_START: begin
          if (!owner_req) begin
            tmr_clear_o <= 1'b1;
            tmr_mode_o  <= MODE_OFF;
            grant_o     <= '0;
            ptr_reg     <= ptr_next;
            state_reg   <= ST_ABORT;
          end else if (tmr_running_i) begin
            state_reg <= ST_WAIT_DONE;
`ifdef TIMER_ARB_TIMEOUT_EN
          end else if (tmo_cnt_reg <= TMO_W'(1)) begin
            err_o       <= grant_o;
            tmr_clear_o <= 1'b1;
            tmr_mode_o  <= MODE_OFF;
            grant_o     <= '0;
            ptr_reg     <= ptr_next;
            state_reg   <= ST_ABORT;
          end else begin
            tmo_cnt_reg <= tmo_cnt_reg - 1'b1;
`endif
          end
        end
        ST_WAIT_DONE: begin
          if (!owner_req) begin
            tmr_clear_o <= 1'b1;
            tmr_mode_o  <= MODE_OFF;
            grant_o     <= '0;
            ptr_reg     <= ptr_next;
            state_reg   <= ST_ABORT;
          end else if (!tmr_running_i) begin
            done_o     <= grant_o;
            grant_o    <= '0;
            tmr_mode_o <= MODE_OFF;
            ptr_reg    <= ptr_next;
            state_reg  <= ST_DONE;
          end
        end
        ST_DONE: begin
          // Grant still set means a zero-delay entry whose pulse is still owed.
          if (grant_o != '0) begin
            done_o     <= grant_o;
            grant_o    <= '0;
            tmr_mode_o <= MODE_OFF;
            ptr_reg    <= ptr_next;
          end else begin
            busy_o    <= 1'b0;
            state_reg <= ST_IDLE;
          end
        end
        ST_ABORT: begin
          busy_o    <= 1'b0;
          state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_timer_arbiter.sv
// Randomized bench for timer_arbiter: a one-shot timer model plus a
// transaction-level reference that predicts grant/done/abort/err cycles.
module tb_timer_arbiter;

  localparam int NUM_REQ    = 4;
  localparam int TW         = 10;
  localparam int TMO_CYC    = 4;
  localparam int STUCK_WAIT = 40;
  localparam int FAR_AWAY   = 1000000;

  typedef enum int {K_DONE, K_ABORT, K_ERR, K_STUCK} kind_e;

  logic                  clk_i = 1'b0;
  logic                  rstn_i = 1'b0;
  logic [NUM_REQ-1:0]    req_i = '0;
  logic [NUM_REQ*TW-1:0] req_delay_i = '0;
  logic                  tmr_running_i;
  logic [NUM_REQ-1:0]    grant_o;
  logic [NUM_REQ-1:0]    done_o;
  logic [NUM_REQ-1:0]    err_o;
  logic                  busy_o;
  logic [1:0]            tmr_mode_o;
  logic [TW-1:0]         tmr_target_o;
  logic                  tmr_trig_o;
  logic                  tmr_clear_o;

  always #5 clk_i = ~clk_i;

  timer_arbiter #(
    .NUM_REQ (NUM_REQ),
    .TW      (TW),
    .TMO_CYC (TMO_CYC)
  ) dut (
    .clk_i         (clk_i),
    .rstn_i        (rstn_i),
    .req_i         (req_i),
    .req_delay_i   (req_delay_i),
    .tmr_running_i (tmr_running_i),
    .grant_o       (grant_o),
    .done_o        (done_o),
    .err_o         (err_o),
    .busy_o        (busy_o),
    .tmr_mode_o    (tmr_mode_o),
    .tmr_target_o  (tmr_target_o),
    .tmr_trig_o    (tmr_trig_o),
    .tmr_clear_o   (tmr_clear_o)
  );

  // One-shot timer: loads target on a trigger rising edge, counts down to 0.
  int unsigned tmr_count = 0;
  logic        trig_prev = 1'b0;
  logic        tmr_dead  = 1'b0;

  always @(posedge clk_i) begin
    trig_prev <= tmr_trig_o;
    if (tmr_clear_o || tmr_mode_o == 2'b00) tmr_count <= 0;
    else if (tmr_trig_o && !trig_prev && !tmr_dead) tmr_count <= tmr_target_o;
    else if (tmr_count != 0) tmr_count <= tmr_count - 1;
  end
  assign tmr_running_i = (tmr_count != 0);

  // Reference state: requester levels and the single service in flight.
  bit    pending [NUM_REQ];
  int    dly     [NUM_REQ];
  int    ptr;
  bit    svc;
  int    s_owner, s_d, s_g, s_end;
  kind_e s_kind;
  int    cyc, n_txn, cand;
  bit    found, act, rst_done;
  int    total, bad;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic drive_inputs();
    for (int k = 0; k < NUM_REQ; k++) begin
      req_i[k] = pending[k];
      req_delay_i[k*TW +: TW] = TW'(dly[k]);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_grant"}, 32'(grant_o), 0);
    check_eq({tag, "_done"}, 32'(done_o), 0);
    check_eq({tag, "_err"}, 32'(err_o), 0);
    check_eq({tag, "_busy"}, 32'(busy_o), 0);
    check_eq({tag, "_mode"}, 32'(tmr_mode_o), 0);
    check_eq({tag, "_target"}, 32'(tmr_target_o), 0);
    check_eq({tag, "_trig"}, 32'(tmr_trig_o), 0);
    check_eq({tag, "_clear"}, 32'(tmr_clear_o), 0);
  endtask

  task automatic raise(input int k);
    if (!pending[k]) begin
      pending[k] = 1'b1;
      dly[k] = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 12));
    end
  endtask

  // Expected outputs for the current cycle, derived from the service record.
  task automatic check_cycle();
    logic [31:0] oh;
    act = svc && cyc >= s_g && cyc <= s_end;
    oh  = 32'(1) << s_owner;
    check_eq("grant", 32'(grant_o), (act && cyc < s_end) ? oh : 0);
    check_eq("busy", 32'(busy_o), 32'(act));
    check_eq("done", 32'(done_o), (act && cyc == s_end && s_kind == K_DONE) ? oh : 0);
    check_eq("err", 32'(err_o), (act && cyc == s_end && s_kind == K_ERR) ? oh : 0);
    check_eq("trig", 32'(tmr_trig_o), 32'(act && s_d > 0 && cyc == s_g + 1));
    check_eq("clear", 32'(tmr_clear_o),
             32'(act && ((s_d > 0 && cyc == s_g) ||
                         (cyc == s_end && (s_kind == K_ABORT || s_kind == K_ERR)))));
    check_eq("mode", 32'(tmr_mode_o), (act && s_d > 0 && cyc < s_end) ? 32'd3 : 32'd0);
    if (act && s_d > 0 && cyc < s_end) check_eq("target", 32'(tmr_target_o), 32'(s_d));
  endtask

  initial begin
    total = 0; bad = 0; ptr = 0; svc = 1'b0; rst_done = 1'b0; n_txn = 0; cyc = -1;
    for (int k = 0; k < NUM_REQ; k++) begin
      pending[k] = 1'b0;
      dly[k] = 0;
    end
    drive_inputs();
    repeat (3) @(posedge clk_i);
    #1;
    check_all_zero("reset");
    @(negedge clk_i);
    rstn_i = 1'b1;

    for (cyc = 0; cyc < 4600; cyc++) begin
      @(posedge clk_i);
      #1;
      check_cycle();

      if (act && cyc == s_end) begin
        pending[s_owner] = 1'b0;
        ptr = (s_owner + 1) % NUM_REQ;
        n_txn++;
        $display("txn %0d owner=%0d delay=%0d grant@%0d end@%0d kind=%s",
                 n_txn, s_owner, s_d, s_g, s_end, s_kind.name());
      end else if (!rst_done && cyc >= 3600 && act && s_kind == K_DONE &&
                   s_d >= 3 && cyc == s_g + 5) begin
        // Reset while the timer is counting; 0 and 3 both wait afterwards.
        raise(0);
        raise(3);
        drive_inputs();
        #1 rstn_i = 1'b0;
        #1 check_all_zero("midrst");
        @(negedge clk_i);
        rstn_i = 1'b1;
        $display("reset mid-run owner=%0d at cyc=%0d", s_owner, cyc);
        svc = 1'b0;
        ptr = 0;
        rst_done = 1'b1;
        act = 1'b0;
      end else if (act && s_d > 0 && cyc >= s_g + 2 && cyc <= s_end - 1 &&
                   ($urandom_range(0, 47) == 0 ||
                    (s_kind == K_STUCK && cyc == s_g + STUCK_WAIT))) begin
        pending[s_owner] = 1'b0;
        s_end  = cyc + 1;
        s_kind = K_ABORT;
      end

      if (cyc < 4200) begin
        for (int k = 0; k < NUM_REQ; k++) begin
          if (!(act && k == s_owner) && $urandom_range(0, 5) == 0) raise(k);
        end
      end
      drive_inputs();

      if (!svc || cyc > s_end) begin
        tmr_dead = (cyc >= 2500 && cyc < 3500);
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
          cand = (ptr + k) % NUM_REQ;
          if (!found && pending[cand]) begin
            found   = 1'b1;
            s_owner = cand;
          end
        end
        if (found) begin
          svc = 1'b1;
          s_g = cyc + 1;
          s_d = dly[s_owner];
          if (s_d == 0) begin
            s_end  = s_g + 1;
            s_kind = K_DONE;
          end else if (!tmr_dead) begin
            s_end  = s_g + s_d + 3;
            s_kind = K_DONE;
          end else begin
`ifdef TIMER_ARB_TIMEOUT_EN
            s_end  = s_g + TMO_CYC + 2;
            s_kind = K_ERR;
`else
            s_end  = FAR_AWAY;
            s_kind = K_STUCK;
`endif
          end
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
